// File: rtl/max_pool_defs.sv
// Shared definitions for the max_pool layer scheduler: FSM encodings,
// pool stride encoding and the output-count width.
`timescale 1ns/1ps
package max_pool_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAD   = 3'd1,
        ST_ROW   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic STRIDE_2  = 1'b0;
    localparam logic STRIDE_1  = 1'b1;
    localparam int   OUT_CNT_W = 16;

endpackage

// File: rtl/pool_addr_gen.sv
// Column/row counters and incremental BRAM address for a row-major feature map.
// The address simply advances by one per read, so it runs straight across row boundaries.
`timescale 1ns/1ps
module pool_addr_gen
    import max_pool_defs::*;
#(
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [COL_W-1:0]  width,
    input  logic [ROW_W-1:0]  height,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              row_end,
    output logic              last_row
);

    logic [COL_W-1:0]  col_q,  col_d;
    logic [ROW_W-1:0]  row_q,  row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign row_end  = (col_q == width  - COL_W'(1));
    assign last_row = (row_q == height - ROW_W'(1));
    assign addr     = addr_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (load) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = base;
        end else if (step) begin
            addr_d = addr_q + ADDR_W'(1);
            if (row_end) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/max_pool_sched.sv
// Sequences one max_pool_8ch layer pass: BRAM row reads with inter-row gaps,
// pool handshake (padding_start, stride, data valid), drain wait and done pulse.
`timescale 1ns/1ps
module max_pool_sched
    import max_pool_defs::*;
#(
    parameter int COL_W     = 8,
    parameter int ROW_W     = 8,
    parameter int ADDR_W    = 12,
    parameter int GAP       = 3,
    parameter int RD_LAT    = 1,
    parameter int DRAIN_CYC = 16
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COL_W-1:0]     cfg_width,
    input  logic [ROW_W-1:0]     cfg_height,
    input  logic                 cfg_stride,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 padding_start,
    output logic                 pool_stride,
    output logic                 data_in_vld,
    input  logic                 pool_out_vld,
    output logic [OUT_CNT_W-1:0] out_cnt
);

    localparam int DRAIN_LEN = RD_LAT + DRAIN_CYC;
    localparam int CNT_W     = $clog2(DRAIN_LEN + GAP + 1);

    function automatic logic [OUT_CNT_W-1:0] sat_inc(input logic [OUT_CNT_W-1:0] v);
        return (&v) ? v : v + OUT_CNT_W'(1);
    endfunction

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [COL_W-1:0]       width_q,   width_d;
    logic [ROW_W-1:0]       height_q,  height_d;
    logic                   stride_q,  stride_d;
    logic [RD_LAT-1:0]      vld_dly_q, vld_dly_d;
    logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic accept;
    logic row_end;
    logic last_row;

    assign accept        = (state_q == ST_IDLE) && start && !abort;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign rd_en         = (state_q == ST_ROW);
    assign padding_start = (state_q == ST_PAD);
    assign pool_stride   = stride_q;
    assign data_in_vld   = vld_dly_q[RD_LAT-1];
    assign out_cnt       = out_cnt_q;

    pool_addr_gen #(
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .load     (accept),
        .base     (cfg_base_addr),
        .width    (width_q),
        .height   (height_q),
        .step     (rd_en),
        .addr     (rd_addr),
        .row_end  (row_end),
        .last_row (last_row)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        height_d = height_q;
        stride_d = stride_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    stride_d = cfg_stride ? STRIDE_1 : STRIDE_2;
                    state_d  = (cfg_width == '0 || cfg_height == '0) ? ST_DONE : ST_PAD;
                end
            end
            ST_PAD: state_d = ST_ROW;
            ST_ROW: begin
                if (row_end) begin
                    if (last_row) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(DRAIN_LEN - 1);
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_ROW;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;

        // data_in_vld follows rd_en by RD_LAT cycles; abort empties the line
        vld_dly_d = '0;
        if (!abort) begin
            vld_dly_d[0] = rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_dly_d[i] = vld_dly_q[i-1];
        end

        out_cnt_d = out_cnt_q;
        if (state_q == ST_PAD)         out_cnt_d = '0;
        else if (busy && pool_out_vld) out_cnt_d = sat_inc(out_cnt_q);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            width_q   <= '0;
            height_q  <= '0;
            stride_q  <= STRIDE_2;
            vld_dly_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            height_q  <= height_d;
            stride_q  <= stride_d;
            vld_dly_q <= vld_dly_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule
